tm1638_responder: RTL and testbench

- Synthesizable TM1638 LED&KEY responder: the device end of the serial LK_CLK/LK_STB/LK_DIO link that the kill_the_bit controller drives.
- Oversamples the three link lines in the CLK domain and decodes commands.
- Exposes display-memory writes and display control to a host-side model/mirror.
- Returns a 32-bit key-scan word on read commands; used for board-less loopback test of the game and as a bench model.

---
 rtl/tm1638_responder.sv | 203 ++++++++++++++++++++
 tb/tb_tm1638_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_responder.sv
// TM1638 LED&KEY responder: the device end of the LK_CLK/LK_STB/LK_DIO serial link.
//
// The three link lines are oversampled in the CLK domain. The responder decodes the
// command bytes, reports display-memory writes and display control to a host-side
// mirror, and returns a 32-bit key-scan word for read commands.
//
// Optional build macro: TM1638_RESP_PROTO_CHECK_EN enables the sticky protocol checker
// behind proto_err. Without the macro proto_err is tied low.
//
// Ports:
//   CLK, rst_n            system clock, synchronous active-low reset
//   lk_clk_i, lk_stb_i    serial clock (idle high) and strobe (active low) from controller
//   lk_dio_i              data line, pad input side
//   lk_dio_o, lk_dio_oe   data line, driven side, used only during key reads
//   key_data              key-scan word; byte0 = [7:0] goes out first, LSB first
//   mem_we/addr/wdata     one-cycle display-memory write strobe, address and data
//   disp_on, brightness   latest display-control settings
//   proto_err             sticky protocol error (checker build only)
module tm1638_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              lk_clk_i,
  input  logic              lk_stb_i,
  input  logic              lk_dio_i,
  output logic              lk_dio_o,
  output logic              lk_dio_oe,
  input  logic [31:0]       key_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              disp_on,
  output logic [2:0]        brightness,
  output logic              proto_err
);

  typedef enum logic [2:0] {StIdle, StCmd, StDataWr, StKeyRd, StWait} state_e;

  // Synchronizers; they reset to 1 because all three lines idle high.
  logic [SYNC_STAGES-1:0] clk_sync_q, stb_sync_q, dio_sync_q;
  logic                   clk_prev_q;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      stb_sync_q <= '1;
      dio_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], lk_clk_i};
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], lk_stb_i};
      dio_sync_q <= {dio_sync_q[SYNC_STAGES-2:0], lk_dio_i};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  logic clk_s, stb_s, dio_s;
  logic clk_rise, clk_fall;
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign dio_s    = dio_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev_q;
  assign clk_fall = ~clk_s & clk_prev_q;

  state_e              state_q;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          shift_q;
  logic [7:0]          shift_d;
  logic                byte_done;
  logic [ADDR_W-1:0]   addr_q;
  logic                fixed_q;
  logic [31:0]         key_q;
  // Counts lk_clk falls in a key read; saturates at 32 (bit 5 set = all bits sent).
  logic [5:0]          fall_cnt_q;
  logic                dio_q, dio_oe_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;
  logic                disp_on_q;
  logic [2:0]          brightness_q;

  // Byte value including the bit arriving on this rise; LSB arrives first.
  assign shift_d   = {dio_s, shift_q[7:1]};
  assign byte_done = clk_rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      fixed_q      <= 1'b0;
      key_q        <= '0;
      fall_cnt_q   <= '0;
      dio_q        <= 1'b0;
      dio_oe_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      disp_on_q    <= 1'b0;
      brightness_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (stb_s) begin
        // Strobe high aborts everything; a partial byte is simply dropped.
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        dio_oe_q  <= 1'b0;
        dio_q     <= 1'b0;
      end else begin
        if (clk_rise) begin
          shift_q   <= shift_d;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        unique case (state_q)
          StIdle: state_q <= StCmd;
          StCmd: begin
            if (byte_done) begin
              unique case (shift_d[7:6])
                2'b01: begin
                  if (shift_d[1]) begin
                    state_q    <= StKeyRd;
                    key_q      <= key_data;
                    fall_cnt_q <= '0;
                  end else begin
                    fixed_q <= shift_d[2];
                    state_q <= StWait;
                  end
                end
                2'b10: begin
                  disp_on_q    <= shift_d[3];
                  brightness_q <= shift_d[2:0];
                  state_q      <= StWait;
                end
                2'b11: begin
                  addr_q  <= shift_d[ADDR_W-1:0];
                  state_q <= StDataWr;
                end
                default: state_q <= StWait;
              endcase
            end
          end
          StDataWr: begin
            if (byte_done) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= shift_d;
              if (!fixed_q) addr_q <= addr_q + ADDR_W'(1);
            end
          end
          StKeyRd: begin
            if (clk_fall) begin
              dio_oe_q <= 1'b1;
              if (!fall_cnt_q[5]) begin
                dio_q      <= key_q[fall_cnt_q[4:0]];
                fall_cnt_q <= fall_cnt_q + 6'd1;
              end else begin
                dio_q <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TM1638_RESP_PROTO_CHECK_EN
  logic stb_prev_q;
  logic proto_err_q;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      stb_prev_q  <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      stb_prev_q <= stb_s;
      // bit_cnt_q still holds the pre-abort count on the cycle the rise is seen.
      if ((stb_s && !stb_prev_q && (bit_cnt_q != 3'd0)) ||
          (clk_fall && stb_s) ||
          (clk_fall && !stb_s && (state_q == StKeyRd) && fall_cnt_q[5])) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

  // Gate with rst_n so the pad is released in the very cycle reset is applied.
  assign lk_dio_oe  = dio_oe_q & rst_n;
  assign lk_dio_o   = dio_q & rst_n;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign disp_on    = disp_on_q;
  assign brightness = brightness_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench for tm1638_responder: directed protocol sequences followed by
// randomized transactions checked against a transaction-level model of the device.
module tb_tm1638_responder;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned AddrW      = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lk_clk = 1'b1;
  logic             lk_stb = 1'b1;
  logic             lk_dio = 1'b1;
  logic             lk_dio_o, lk_dio_oe;
  logic [31:0]      key_data = '0;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [7:0]       mem_wdata;
  logic             disp_on;
  logic [2:0]       brightness;
  logic             proto_err;

  always #5 clk = ~clk;

  tm1638_responder #(
    .SYNC_STAGES(SyncStages),
    .ADDR_W     (AddrW)
  ) dut (
    .CLK       (clk),
    .rst_n     (rst_n),
    .lk_clk_i  (lk_clk),
    .lk_stb_i  (lk_stb),
    .lk_dio_i  (lk_dio),
    .lk_dio_o  (lk_dio_o),
    .lk_dio_oe (lk_dio_oe),
    .key_data  (key_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .disp_on   (disp_on),
    .brightness(brightness),
    .proto_err (proto_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int         m_addr  = 0;
  bit         m_fixed = 1'b0;
  bit         m_on    = 1'b0;
  bit [2:0]   m_br    = 3'd0;
  bit         m_err   = 1'b0;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  logic [7:0]  tx_q[$];

  always @(negedge clk) begin
    if (rst_n && mem_we) got_q.push_back({mem_addr, mem_wdata});
  end

  task automatic half_bit();
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      lk_clk = 1'b0;
      lk_dio = b[i];
      half_bit();
      lk_clk = 1'b1;
      half_bit();
    end
    lk_dio = 1'b1;
  endtask

  // Apply one complete transaction in tx_q to the model.
  task automatic model_txn();
    logic [7:0] c;
    if (tx_q.size() == 0) return;
    c = tx_q[0];
    case (c[7:6])
      2'b01: if (!c[1]) m_fixed = c[2];
      2'b10: begin
        m_on = c[3];
        m_br = c[2:0];
      end
      2'b11: begin
        m_addr = c[3:0];
        for (int i = 1; i < tx_q.size(); i++) begin
          exp_q.push_back({4'(m_addr), tx_q[i]});
          if (!m_fixed) m_addr = (m_addr + 1) % 16;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_txn(input string tag);
    int n;
    check_eq({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_wr"}, 64'(got_q[i]), 64'(exp_q[i]));
    check_eq({tag, "_disp_on"}, 64'(disp_on), 64'(m_on));
    check_eq({tag, "_bright"}, 64'(brightness), 64'(m_br));
    check_eq({tag, "_perr"}, 64'(proto_err), 64'(m_err));
  endtask

  task automatic do_txn(input string tag);
    got_q.delete();
    exp_q.delete();
    lk_stb = 1'b0;
    half_bit();
    foreach (tx_q[i]) send_bits(tx_q[i], 8);
    lk_stb = 1'b1;
    repeat (8) @(negedge clk);
    model_txn();
    compare_txn(tag);
  endtask

  task automatic key_read(input logic [31:0] k, input logic [7:0] cmd, input int nclk);
    logic [31:0] rd;
    rd = '0;
    got_q.delete();
    exp_q.delete();
    key_data = k;
    lk_stb = 1'b0;
    half_bit();
    send_bits(cmd, 8);
    key_data = $urandom();  // must not affect the snapshot already taken
    for (int i = 0; i < nclk; i++) begin
      lk_clk = 1'b0;
      half_bit();
      if (i < 32) rd[i] = lk_dio_o;
      else check_eq("key_extra_bit", 64'(lk_dio_o), 64'd0);
      if (i == 0) check_eq("key_oe_on", 64'(lk_dio_oe), 64'd1);
      lk_clk = 1'b1;
      half_bit();
    end
    check_eq("key_word", 64'(rd), 64'(k));
`ifdef TM1638_RESP_PROTO_CHECK_EN
    if (nclk > 32) m_err = 1'b1;
`endif
    lk_stb = 1'b1;
    repeat (SyncStages + 1) @(posedge clk);
    #1;
    check_eq("key_oe_off", 64'(lk_dio_oe), 64'd0);
    repeat (6) @(negedge clk);
    compare_txn("key");
  endtask

  task automatic abort_txn(input logic [7:0] acmd, input logic [7:0] d);
    got_q.delete();
    exp_q.delete();
    lk_stb = 1'b0;
    half_bit();
    send_bits(acmd, 8);
    send_bits(d, 5);
    lk_stb = 1'b1;
    repeat (8) @(negedge clk);
    m_addr = acmd[3:0];
`ifdef TM1638_RESP_PROTO_CHECK_EN
    m_err = 1'b1;
`endif
    compare_txn("abort");
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"}, 64'(mem_we), 64'd0);
    check_eq({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check_eq({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    check_eq({tag, "_disp_on"}, 64'(disp_on), 64'd0);
    check_eq({tag, "_bright"}, 64'(brightness), 64'd0);
    check_eq({tag, "_oe"}, 64'(lk_dio_oe), 64'd0);
    check_eq({tag, "_dio"}, 64'(lk_dio_o), 64'd0);
    check_eq({tag, "_perr"}, 64'(proto_err), 64'd0);
  endtask

  initial begin
    int kind;
    int n;

    // Reset with lines idle
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("post_rst");

    // Directed sequences
    tx_q = '{8'h8F};                      do_txn("disp_8f");
    tx_q = '{8'h40};                      do_txn("mode_auto");
    tx_q = '{8'hC0, 8'h3F, 8'h06, 8'h5B}; do_txn("burst");
    tx_q = '{8'hCF, 8'hAA, 8'h55};        do_txn("wrap");
    tx_q = '{8'h44};                      do_txn("mode_fixed");
    tx_q = '{8'hC5, 8'h11, 8'h22};        do_txn("fixed");
    key_read(32'h8001_0201, 8'h42, 32);
    abort_txn(8'hC3, 8'h5A);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      tx_q.delete();
      case (kind)
        0: begin
          tx_q.push_back(8'h40 | 8'($urandom() & 32'h3D));
          do_txn("rnd_mode");
        end
        1: begin
          tx_q.push_back(8'h80 | 8'($urandom() & 32'h3F));
          do_txn("rnd_disp");
        end
        2: begin
          tx_q.push_back(8'hC0 | 8'($urandom() & 32'h3F));
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom()));
          do_txn("rnd_write");
        end
        3: key_read($urandom(), 8'h42 | 8'($urandom() & 32'h04), 32);
        default: begin
          tx_q.push_back(8'($urandom() & 32'h3F));
          tx_q.push_back(8'($urandom()));
          do_txn("rnd_junk");
        end
      endcase
    end

    // Extra clocks beyond 32 during a key read drive 0
    key_read($urandom() | 32'h1, 8'h42, 34);

    // Reset in the middle of a key read releases the pad immediately
    lk_stb = 1'b0;
    half_bit();
    send_bits(8'h42, 8);
    for (int i = 0; i < 3; i++) begin
      lk_clk = 1'b0;
      half_bit();
      lk_clk = 1'b1;
      half_bit();
    end
    check_eq("mr_oe_before", 64'(lk_dio_oe), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_oe_now", 64'(lk_dio_oe), 64'd0);
    lk_stb = 1'b1;
    lk_clk = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("mr_rst");
    rst_n = 1'b1;
    m_addr  = 0;
    m_fixed = 1'b0;
    m_on    = 1'b0;
    m_br    = 3'd0;
    m_err   = 1'b0;
    repeat (3) @(negedge clk);
    tx_q = '{8'hC2, 8'h12, 8'h34};
    do_txn("post_mr");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
